// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Writeback arbiter: picks one of N_REQ requesters (0 = ALU, 1 = FPU,
//   2 = MEM) each cycle and drives a shared registered write port into
//   the integer or float register file.
//
//   Configuration macro: WB_ROUND_ROBIN_EN
//     defined   -> round-robin arbitration from a rotating priority pointer
//     undefined -> fixed priority, lowest index wins (pointer held at 0)
//
//   Ports
//     clk            in   clock, all state on posedge
//     rstn           in   synchronous active-low reset
//     req_valid      in   [N_REQ]    per-requester write request
//     req_freg       in   [N_REQ]    1 = float regfile, 0 = integer regfile
//     req_dest       in   [5*N_REQ]  destination, requester i at [5i+4:5i]
//     req_data       in   [32*N_REQ] write data, requester i at [32i+31:32i]
//     req_ready      out  [N_REQ]    combinational one-hot (or zero) grant
//     reg_w_enable   out             integer regfile write strobe (registered)
//     freg_w_enable  out             float regfile write strobe (registered)
//     reg_w_dest     out  [5]        registered destination (both files)
//     reg_w_data     out  [32]       registered write data (both files)
//     retired_count  out  [32]       accepted transfers since reset
module wb_arbiter #(
   parameter int N_REQ = 3
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ-1:0]      req_freg,
   input  logic [5*N_REQ-1:0]    req_dest,
   input  logic [32*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  reg_w_enable,
   output logic                  freg_w_enable,
   output logic [4:0]            reg_w_dest,
   output logic [31:0]           reg_w_data,
   output logic [31:0]           retired_count
);

   localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [IDXW-1:0] ptr_q, ptr_d;
   logic            reg_w_en_q, freg_w_en_q;
   logic [4:0]      dest_q;
   logic [31:0]     data_q;
   logic [31:0]     retired_q;

   logic [N_REQ-1:0] grant;
   logic [IDXW-1:0]  gidx;
   logic             xfer;
   logic             found;
   logic             sel_freg;
   logic [4:0]       sel_dest;
   logic [31:0]      sel_data;
   int               idx;

   // Scan from ptr upward (wrapping) and grant the first valid requester.
   // Grants are suppressed entirely while reset is asserted.
   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      if (rstn) begin
         for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[IDXW'(idx)]) begin
               found = 1'b1;
               grant[IDXW'(idx)] = 1'b1;
               gidx = IDXW'(idx);
            end
         end
      end
   end

   assign xfer = found;

   always_comb begin
      sel_freg = req_freg[gidx];
      sel_dest = req_dest[int'(gidx)*5 +: 5];
      sel_data = req_data[int'(gidx)*32 +: 32];
   end

`ifdef WB_ROUND_ROBIN_EN
   // After a transfer the requester just served drops to lowest priority.
   always_comb begin
      ptr_d = ptr_q;
      if (xfer)
         ptr_d = (gidx == IDXW'(N_REQ-1)) ? '0 : gidx + 1'b1;
   end
`else
   always_comb begin
      ptr_d = '0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q       <= '0;
         reg_w_en_q  <= 1'b0;
         freg_w_en_q <= 1'b0;
         dest_q      <= '0;
         data_q      <= '0;
         retired_q   <= '0;
      end else begin
         // Integer x0 is accepted and counted but never strobed.
         reg_w_en_q  <= xfer && !sel_freg && (sel_dest != 5'd0);
         freg_w_en_q <= xfer && sel_freg;
         if (xfer) begin
            ptr_q     <= ptr_d;
            dest_q    <= sel_dest;
            data_q    <= sel_data;
            retired_q <= retired_q + 32'd1;
         end
      end
   end

   assign req_ready     = grant;
   assign reg_w_enable  = reg_w_en_q;
   assign freg_w_enable = freg_w_en_q;
   assign reg_w_dest    = dest_q;
   assign reg_w_data    = data_q;
   assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter. Inputs change 1ns after
// each rising edge; combinational grants are sampled 1ns later and
// registered outputs 1ns after the following rising edge.
module tb_wb_arbiter;

   localparam int N = 3;

   logic          clk;
   logic          rstn;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_freg;
   logic [5*N-1:0]  req_dest;
   logic [32*N-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          reg_w_enable;
   logic          freg_w_enable;
   logic [4:0]    reg_w_dest;
   logic [31:0]   reg_w_data;
   logic [31:0]   retired_count;

   int checks = 0;
   int failures = 0;

   wb_arbiter #(.N_REQ(N)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_freg(req_freg),
      .req_dest(req_dest), .req_data(req_data),
      .req_ready(req_ready),
      .reg_w_enable(reg_w_enable), .freg_w_enable(freg_w_enable),
      .reg_w_dest(reg_w_dest), .reg_w_data(reg_w_data),
      .retired_count(retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic fr, input logic [4:0] d, input logic [31:0] v);
      req_freg[i]         = fr;
      req_dest[i*5 +: 5]  = d;
      req_data[i*32 +: 32] = v;
   endtask

   logic [N-1:0] exp_g;
   logic [N-1:0] prio_exp [3];

   initial begin
      rstn = 1'b0;
      req_valid = '0; req_freg = '0; req_dest = '0; req_data = '0;

      // ---- reset: grant forced low even with requests pending
      tick();
      req_valid = 3'b111;
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      tick();
      chk("rst_wen",   32'(reg_w_enable), 32'h0);
      chk("rst_fwen",  32'(freg_w_enable), 32'h0);
      chk("rst_dest",  32'(reg_w_dest), 32'h0);
      chk("rst_data",  reg_w_data, 32'h0);
      chk("rst_cnt",   retired_count, 32'h0);
      req_valid = '0;
      rstn = 1'b1;
      #1;
      chk("idle_ready", 32'(req_ready), 32'h0);
      tick();

      // ---- single float request from FPU
      set_req(1, 1'b1, 5'd3, 32'h3F800000);
      req_valid = 3'b010;
      #1;
      chk("single_ready", 32'(req_ready), 32'b010);
      tick();
      req_valid = '0;
      chk("single_fwen", 32'(freg_w_enable), 32'h1);
      chk("single_wen",  32'(reg_w_enable), 32'h0);
      chk("single_dest", 32'(reg_w_dest), 32'd3);
      chk("single_data", reg_w_data, 32'h3F800000);
      chk("single_cnt",  retired_count, 32'd1);
      tick();
      chk("bubble_fwen", 32'(freg_w_enable), 32'h0);
      chk("bubble_wen",  32'(reg_w_enable), 32'h0);
      chk("bubble_dest", 32'(reg_w_dest), 32'd3);
      chk("bubble_data", reg_w_data, 32'h3F800000);

      // ---- integer x0: accepted and counted, no strobe
      set_req(0, 1'b0, 5'd0, 32'hDEADBEEF);
      req_valid = 3'b001;
      #1;
      chk("x0_ready", 32'(req_ready), 32'b001);
      tick();
      req_valid = '0;
      chk("x0_wen",  32'(reg_w_enable), 32'h0);
      chk("x0_fwen", 32'(freg_w_enable), 32'h0);
      chk("x0_cnt",  retired_count, 32'd2);

      // ---- float dest 0 is written normally
      set_req(1, 1'b1, 5'd0, 32'h40000000);
      req_valid = 3'b010;
      #1;
      chk("f0_ready", 32'(req_ready), 32'b010);
      tick();
      req_valid = '0;
      chk("f0_fwen", 32'(freg_w_enable), 32'h1);
      chk("f0_data", reg_w_data, 32'h40000000);

      // ---- normal integer write from MEM
      set_req(2, 1'b0, 5'd7, 32'h12345678);
      req_valid = 3'b100;
      #1;
      chk("int_ready", 32'(req_ready), 32'b100);
      tick();
      req_valid = '0;
      chk("int_wen",  32'(reg_w_enable), 32'h1);
      chk("int_fwen", 32'(freg_w_enable), 32'h0);
      chk("int_dest", 32'(reg_w_dest), 32'd7);
      chk("int_cnt",  retired_count, 32'd4);

      // ---- all three valid for 6 cycles straight out of reset
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'(10 + i), 32'hA0 + 32'(i));
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
`ifdef WB_ROUND_ROBIN_EN
         exp_g = 3'(1 << (c % 3));
`else
         exp_g = 3'b001;
`endif
         #1;
         chk("all_ready", 32'(req_ready), 32'(exp_g));
         tick();
         chk("all_wen",  32'(reg_w_enable), 32'h1);
         chk("all_dest", 32'(reg_w_dest), (exp_g == 3'b001) ? 32'd10 :
                                          (exp_g == 3'b010) ? 32'd11 : 32'd12);
         chk("all_cnt",  retired_count, 32'(c + 1));
      end
      req_valid = '0;

      // ---- requesters 0 and 2 contend for 3 cycles, then 0 drops
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
`ifdef WB_ROUND_ROBIN_EN
      prio_exp[0] = 3'b001; prio_exp[1] = 3'b100; prio_exp[2] = 3'b001;
`else
      prio_exp[0] = 3'b001; prio_exp[1] = 3'b001; prio_exp[2] = 3'b001;
`endif
      req_valid = 3'b101;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("prio_ready", 32'(req_ready), 32'(prio_exp[c]));
         tick();
      end
      req_valid = 3'b100;
      #1;
      chk("prio_late2", 32'(req_ready), 32'b100);
      tick();
      req_valid = '0;
      chk("prio_cnt", retired_count, 32'd4);

      // ---- reset arriving the cycle after a grant to dest 5
      set_req(2, 1'b0, 5'd5, 32'h55);
      req_valid = 3'b100;
      #1;
      chk("mid_ready", 32'(req_ready), 32'b100);
      tick();
      rstn = 1'b0;
      req_valid = 3'b110;
      #1;
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      tick();
      chk("mid_wen",  32'(reg_w_enable), 32'h0);
      chk("mid_fwen", 32'(freg_w_enable), 32'h0);
      chk("mid_cnt",  retired_count, 32'h0);
      chk("mid_dest", 32'(reg_w_dest), 32'h0);
      rstn = 1'b1;
      set_req(1, 1'b0, 5'd9, 32'h99);
      #1;
      chk("post_ready", 32'(req_ready), 32'b010);
      tick();
      req_valid = '0;
      chk("post_dest", 32'(reg_w_dest), 32'd9);
      chk("post_cnt",  retired_count, 32'd1);

      // ---- counter wrap
      force dut.retired_q = 32'hFFFFFFFF;
      #1;
      release dut.retired_q;
      chk("wrap_pre", retired_count, 32'hFFFFFFFF);
      set_req(0, 1'b0, 5'd1, 32'h1);
      req_valid = 3'b001;
      tick();
      req_valid = '0;
      chk("wrap_cnt", retired_count, 32'h0);
      tick();
      chk("wrap_hold", retired_count, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter: N_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = FPU, 2 = MEM).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port: rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req_valid  input  N_REQ  per-requester write request.
REQ-005 SHALL have port: req_freg  input  N_REQ  1 = target float regfile, 0 = integer regfile.
REQ-006 SHALL have port: req_dest  input  5*N_REQ  destination register, requester i in bits [5i+4:5i].
REQ-007 SHALL have port: req_data  input  32*N_REQ  write data, requester i in bits [32i+31:32i].
REQ-008 SHALL have port: req_ready  output  N_REQ  grant; one-hot or zero; combinational.
REQ-009 SHALL have port: reg_w_enable  output  1  registered integer regfile write strobe.
REQ-010 SHALL have port: freg_w_enable  output  1  registered float regfile write strobe.
REQ-011 SHALL have port: reg_w_dest  output  5  registered destination, shared by both files.
REQ-012 SHALL have port: reg_w_data  output  32  registered write data, shared by both files.
REQ-013 SHALL have port: retired_count  output  32  count of accepted requests since reset.

Function
REQ-014 SHALL complete a transfer on requester i in a cycle where req_valid[i] && req_ready[i]; requester holds valid/freg/dest/data stable until then.
REQ-015 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid set.
REQ-016 SHALL assert req_ready for some requester in every cycle where any req_valid bit is set and rstn is high (one write per cycle, no bubbles).
REQ-017 SHALL drive write port registered from the granted request: a transfer in cycle N appears on reg_w_dest/reg_w_data and the selected strobe in cycle N+1 only (latency 1, strobe one cycle wide).
REQ-018 SHALL assert freg_w_enable when granted req_freg=1, reg_w_enable when req_freg=0; never both.
REQ-019 SHALL accept an integer request with dest 0 (ready asserted, counted) but keep reg_w_enable low for it; float dest 0 is written normally.
REQ-020 SHALL deassert both strobes in any cycle following one with no transfer; reg_w_dest/reg_w_data then hold last values.
REQ-021 SHALL increment retired_count by 1 per transfer, wrapping 0xFFFFFFFF -> 0.
REQ-022 SHALL hold a priority pointer ptr (0..N_REQ-1); arbitration scans ptr, ptr+1, ... mod N_REQ and grants first valid.
REQ-023 SHALL update ptr after a transfer by requester g to (g+1) mod N_REQ; ptr unchanged when no transfer.

Reset
REQ-024 SHALL, in any cycle with rstn low, force req_ready=0 combinationally and on the clock edge set reg_w_enable=0, freg_w_enable=0, reg_w_dest=0, reg_w_data=0, retired_count=0, ptr=0.
REQ-025 SHALL discard any transfer granted in the cycle before a reset edge: its write is not emitted after reset.
REQ-026 SHALL resume normal arbitration the first cycle rstn is high, ptr=0.

Configuration
REQ-027 SHALL, with WB_ROUND_ROBIN_EN defined, use round-robin per REQ-022/023.
REQ-028 SHALL, without WB_ROUND_ROBIN_EN, use fixed priority (lowest index wins), ptr held at 0; all other requirements unchanged.

Verification
REQ-029 SHALL test single request: req 1 valid, freg=1, dest=3, data=0x3F800000 in cycle N -> ready[1] in N; freg_w_enable=1, dest=3, data=0x3F800000 in N+1; retired_count=1.
REQ-030 SHALL test round-robin: all three valid continuously for 6 cycles from reset -> grants 0,1,2,0,1,2; six one-cycle strobes back-to-back.
REQ-031 SHALL test fixed priority (macro undefined): reqs 0 and 2 valid 3 cycles -> ready[0] every cycle, req 2 granted only after req 0 drops.
REQ-032 SHALL test x0: req 0 valid, freg=0, dest=0, data=0xDEADBEEF -> ready[0]=1, reg_w_enable stays 0 next cycle, retired_count increments.
REQ-033 SHALL test reset mid-stream: rstn low in cycle after a grant of dest=5 -> no strobe after reset, retired_count=0, first post-reset grant goes to lowest valid index.
REQ-034 SHALL test counter wrap: retired_count forced 0xFFFFFFFF, one transfer -> 0x00000000.
